// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : apb_master_bridge
//  Brief   : valid/ready command port to APB3 master, one transfer in flight,
//            with PREADY wait states, PSLVERR capture and an ACCESS watchdog.
//  Rev     : 1.0  initial release
// ============================================================================
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  rstN,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic                  cmdWrite,
   input  logic [ADDR_WIDTH-1:0] cmdAddr,
   input  logic [DATA_WIDTH-1:0] cmdWdata,
   output logic                  rspValid,
   output logic [DATA_WIDTH-1:0] rspRdata,
   output logic                  rspErr,
   output logic                  rspTimeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int c_WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);
   localparam bit c_WD_EN = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                r_state;
   logic [c_WD_W-1:0]     r_wd_cnt;
   logic                  r_cmd_ready;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_rsp_timeout;

   logic [c_WD_W-1:0]     w_wd_next;
   logic                  w_wd_expire;

   assign w_wd_next   = r_wd_cnt + 1'b1;
   // Expiry is judged on the count this ACCESS cycle would complete.
   assign w_wd_expire = c_WD_EN && (w_wd_next == c_WD_LIMIT);

   always_ff @(posedge pclk or negedge rstN) begin
      if (!rstN) begin
         r_state       <= S_IDLE;
         r_wd_cnt      <= '0;
         r_cmd_ready   <= 1'b1;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmdValid && r_cmd_ready) begin
                  r_paddr     <= cmdAddr;
                  r_pwrite    <= cmdWrite;
                  r_pwdata    <= cmdWrite ? cmdWdata : '0;
                  r_psel      <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_wd_cnt    <= '0;
                  r_state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               // A ready slave wins over a watchdog expiring on the same edge.
               if (pready) begin
                  r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                  r_rsp_err     <= pslverr;
                  r_rsp_timeout <= 1'b0;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= S_RESP;
               end else if (w_wd_expire) begin
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= S_RESP;
               end else begin
                  r_wd_cnt <= w_wd_next;
               end
            end
            S_RESP: begin
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign cmdReady   = r_cmd_ready;
   assign psel       = r_psel;
   assign penable    = r_penable;
   assign pwrite     = r_pwrite;
   assign paddr      = r_paddr;
   assign pwdata     = r_pwdata;
   assign rspValid   = r_rsp_valid;
   assign rspRdata   = r_rsp_rdata;
   assign rspErr     = r_rsp_err;
   assign rspTimeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command interface into APB3 transfers that drive the apb_if bus into apb_slave.
- Sits directly upstream of apb_slave and replaces the testbench-driven bus tasks with synthesizable RTL.
- Handles one outstanding transfer at a time, with PREADY wait states, PSLVERR capture and a watchdog timeout.
- Returns a one-cycle response pulse per command.

Parameters:
- ADDR_WIDTH, 8, width of cmdAddr and paddr.
- DATA_WIDTH, 32, width of the write data, read data, pwdata and prdata.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles allowed before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic is rising-edge.
- rstN  in  1  asynchronous active-low reset.
- cmdValid  in  1  command request.
- cmdReady  out  1  bridge can accept a command this cycle.
- cmdWrite  in  1  1 = write, 0 = read.
- cmdAddr  in  ADDR_WIDTH  transfer address.
- cmdWdata  in  DATA_WIDTH  write data; ignored on reads.
- rspValid  out  1  one-cycle pulse: transfer finished.
- rspRdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rspErr  out  1  PSLVERR sampled, or timeout.
- rspTimeout  out  1  transfer aborted by the watchdog.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (rstN low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0 except cmdReady, which is 1 once in IDLE after reset.
  - Watchdog counter clears.
  - Reset mid-transfer drops psel/penable immediately and produces no response.
- FSM states:
  - IDLE: cmdReady=1, psel=0, penable=0. A handshake (cmdValid & cmdReady at the edge) latches cmdWrite/cmdAddr/cmdWdata and moves to SETUP. With no handshake, stay in IDLE.
  - SETUP: psel=1, penable=0, cmdReady=0. paddr/pwrite come from the latched values. pwdata = latched data on writes, 0 on reads. Always moves to ACCESS after 1 cycle.
  - ACCESS: psel=1, penable=1, cmdReady=0, with paddr/pwrite/pwdata held stable. The watchdog increments each ACCESS cycle.
    - pready=1 at an edge: transfer completes and the FSM moves to RESP.
    - Otherwise the FSM stays in ACCESS.
  - RESP: psel=0, penable=0, rspValid=1 for exactly 1 cycle, cmdReady=0. Always moves to IDLE.
- Response capture, registered on the completing edge:
  - Read: rspRdata = prdata.
  - Write: rspRdata = 0.
  - rspErr = pslverr; rspTimeout = 0.
  - rspRdata/rspErr/rspTimeout hold their values until the next RESP. Only rspValid pulses.
- Watchdog:
  - Applies when TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES with pready still 0.
  - Abort: move to RESP with rspErr=1, rspTimeout=1, rspRdata=0. psel/penable deassert in RESP.
  - A pready=1 on the same edge as the counter reaching TIMEOUT_CYCLES takes priority and completes normally.
  - Counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP.
- Latency:
  - Zero-wait transfer: handshake edge, SETUP, ACCESS, RESP, giving rspValid 3 cycles after the handshake edge.
  - Each wait state adds 1 cycle.
  - Minimum command-to-command spacing is 4 cycles, because IDLE is always revisited.
- pslverr and prdata are sampled only in ACCESS with pready=1; they are ignored otherwise.
- cmdValid in any non-IDLE state is ignored (not accepted). The upstream side must hold it until cmdReady.

Test Plan:
- Reset sequence: hold rstN high 5 cycles, low 5 cycles, then high -> all APB outputs 0 and cmdReady=1 after release; no rspValid pulse.
- Write 0x10 to addr 0x02 with pready tied 1 -> SETUP then ACCESS with paddr=0x02, pwrite=1, pwdata=0x10; rspValid 3 cycles after the handshake; rspErr=0.
- Read addr 0x02 with apb_slave holding 0x10 -> rspRdata=0x10, pwdata=0 during the transfer. Repeat with 0x04/0x20 and 0x08/0x10, all matching.
- Read with pready low for 3 ACCESS cycles -> penable high for 4 cycles with paddr stable; rspValid 6 cycles after the handshake; pslverr=1 on the completing edge gives rspErr=1, rspTimeout=0.
- pready held 0 with TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles; rspErr=1, rspTimeout=1, rspRdata=0; the next command is accepted normally.
- rstN asserted during ACCESS -> psel/penable go to 0 asynchronously, no rspValid; after release a new write completes correctly.
